// File: rtl/counter_pkg.sv
// Shared definitions for the counter subsystem: counting-mode constants and
// a range-clamp helper that every counter block uses for parallel loads.
package counter_pkg;

    // Behaviour at the range ends: roll over to the opposite end, or stick.
    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Wide enough for any supported counter width plus one guard bit.
    localparam int unsigned CLAMP_W = 33;

    // Force a value into min_val..max_val; values already inside pass through.
    function automatic logic [CLAMP_W-1:0] clamp_range(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] min_val,
        input logic [CLAMP_W-1:0] max_val
    );
        if (value < min_val) begin
            return min_val;
        end
        if (value > max_val) begin
            return max_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter over MIN_VAL..MAX_VAL with enable, clear,
// clamped parallel load, wrap/saturate mode, terminal-count flags and a
// registered carry/borrow pulse that can drive the enable of a next stage.
module up_down_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter longint      MIN_VAL   = 0,
    parameter longint      MAX_VAL   = (longint'(1) << WIDTH) - 1,
    parameter longint      RESET_VAL = MIN_VAL,
    parameter bit          SATURATE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             carry_pulse
);

    // The extra top bit keeps every compare and increment free of overflow;
    // it is always zero in the stored count.
    typedef logic [WIDTH:0] wide_t;

    localparam wide_t MIN_W   = wide_t'(MIN_VAL);
    localparam wide_t MAX_W   = wide_t'(MAX_VAL);
    localparam wide_t RESET_W = wide_t'(RESET_VAL);
    localparam wide_t ONE_W   = wide_t'(1);

    // Reject illegal parameter combinations while elaborating.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("up_down_counter_param: WIDTH must be 1..32");
    end
    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_bad_range
        $error("up_down_counter_param: need 0 <= MIN_VAL < MAX_VAL");
    end
    if (MAX_VAL > (longint'(1) << WIDTH) - 1) begin : g_bad_max
        $error("up_down_counter_param: MAX_VAL does not fit in WIDTH bits");
    end
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("up_down_counter_param: RESET_VAL outside MIN_VAL..MAX_VAL");
    end

    wide_t count_r;
    logic  carry_r;
    wide_t next_count;
    logic  next_carry;
    wide_t clamped_load;

    // Load values outside the legal range are pulled onto the nearer end.
    always_comb begin
        clamped_load = wide_t'(clamp_range(CLAMP_W'(load_val),
                                           CLAMP_W'(MIN_VAL),
                                           CLAMP_W'(MAX_VAL)));
    end

    // Next count and carry decode, priority clear > load > en > hold.
    always_comb begin
        next_count = count_r;
        next_carry = 1'b0;
        if (clear) begin
            next_count = RESET_W;
        end else if (load) begin
            next_count = clamped_load;
        end else if (en) begin
            if (up_down) begin
                if (count_r >= MAX_W) begin
                    next_carry = 1'b1;
                    next_count = (SATURATE == CNT_SAT) ? MAX_W : MIN_W;
                end else begin
                    next_count = count_r + ONE_W;
                end
            end else begin
                if (count_r <= MIN_W) begin
                    next_carry = 1'b1;
                    next_count = (SATURATE == CNT_SAT) ? MIN_W : MAX_W;
                end else begin
                    next_count = count_r - ONE_W;
                end
            end
        end
    end

    // Count and carry registers; reset drops any pending pulse at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= RESET_W;
            carry_r <= 1'b0;
        end else begin
            count_r <= next_count;
            carry_r <= next_carry;
        end
    end

    assign count       = count_r[WIDTH-1:0];
    assign at_max      = (count_r == MAX_W);
    assign at_min      = (count_r == MIN_W);
    assign carry_pulse = carry_r;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Directed bench for up_down_counter_param. Five instances with different
// ranges/modes share one set of control inputs; each step checks the
// instance that the step targets.
module tb_up_down_counter_param;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_down;

    logic [3:0] cnt_def, cnt_wrp, cnt_sat, cnt_pri, cnt_mid;
    logic       max_def, max_wrp, max_sat, max_pri, max_mid;
    logic       min_def, min_wrp, min_sat, min_pri, min_mid;
    logic       cy_def, cy_wrp, cy_sat, cy_pri, cy_mid;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    // Defaults: 0..15, wrap.
    up_down_counter_param u_def (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .count(cnt_def), .at_max(max_def),
        .at_min(min_def), .carry_pulse(cy_def));

    // Narrow range 3..9, wrap.
    up_down_counter_param #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(9)) u_wrp (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .count(cnt_wrp), .at_max(max_wrp),
        .at_min(min_wrp), .carry_pulse(cy_wrp));

    // 0..15, saturate.
    up_down_counter_param #(.WIDTH(4), .SATURATE(CNT_SAT)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .count(cnt_sat), .at_max(max_sat),
        .at_min(min_sat), .carry_pulse(cy_sat));

    // 2..10 with reset value 5, for priority and clamp checks.
    up_down_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(10), .RESET_VAL(5)) u_pri (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .count(cnt_pri), .at_max(max_pri),
        .at_min(min_pri), .carry_pulse(cy_pri));

    // 7..12 with reset value 9: wrapping up lands on 7 with carry high.
    up_down_counter_param #(.WIDTH(4), .MIN_VAL(7), .MAX_VAL(12), .RESET_VAL(9)) u_mid (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .count(cnt_mid), .at_max(max_mid),
        .at_min(min_mid), .carry_pulse(cy_mid));

    // Drive one edge worth of controls, then sample 1 ns after the edge.
    task automatic applyStimulus(input logic c, input logic l, input logic [3:0] lv,
                                 input logic e, input logic ud);
        clear    = c;
        load     = l;
        load_val = lv;
        en       = e;
        up_down  = ud;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        en       = 1'b0;
        up_down  = 1'b0;
        #20;

        // Reset state
        checkOutput("rst def count", 32'(cnt_def), 0);
        checkOutput("rst def at_min", 32'(min_def), 1);
        checkOutput("rst def at_max", 32'(max_def), 0);
        checkOutput("rst def carry", 32'(cy_def), 0);
        checkOutput("rst pri count", 32'(cnt_pri), 5);
        checkOutput("rst wrp count", 32'(cnt_wrp), 3);

        // Count up five clocks from 0
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            checkOutput("def up", 32'(cnt_def), 32'(i));
        end

        // Count back down to 0
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            checkOutput("def down", 32'(cnt_def), 32'(i));
        end
        checkOutput("def at_min end", 32'(min_def), 1);
        checkOutput("def carry none", 32'(cy_def), 0);

        // Wrap up 15 -> 0 with one-cycle carry
        applyStimulus(1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
        checkOutput("def load14", 32'(cnt_def), 14);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("def 15", 32'(cnt_def), 15);
        checkOutput("def at_max", 32'(max_def), 1);
        checkOutput("def carry pre", 32'(cy_def), 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("def wrap 0", 32'(cnt_def), 0);
        checkOutput("def wrap carry", 32'(cy_def), 1);
        checkOutput("def wrap at_max", 32'(max_def), 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("def after wrap", 32'(cnt_def), 1);
        checkOutput("def carry drop", 32'(cy_def), 0);

        // Wrap down 3 -> 9 in the narrow range
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        checkOutput("wrp load3", 32'(cnt_wrp), 3);
        checkOutput("wrp at_min", 32'(min_wrp), 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("wrp down 9", 32'(cnt_wrp), 9);
        checkOutput("wrp carry", 32'(cy_wrp), 1);
        checkOutput("wrp at_max", 32'(max_wrp), 1);

        // Saturate up from 13
        applyStimulus(1'b0, 1'b1, 4'd13, 1'b0, 1'b1);
        checkOutput("sat load13", 32'(cnt_sat), 13);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("sat 14", 32'(cnt_sat), 14);
        checkOutput("sat 14 carry", 32'(cy_sat), 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("sat 15", 32'(cnt_sat), 15);
        checkOutput("sat 15 carry", 32'(cy_sat), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            checkOutput("sat hold 15", 32'(cnt_sat), 15);
            checkOutput("sat hold carry", 32'(cy_sat), 1);
        end

        // Saturate down from 1
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        checkOutput("sat load1", 32'(cnt_sat), 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("sat 0", 32'(cnt_sat), 0);
        checkOutput("sat 0 carry", 32'(cy_sat), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            checkOutput("sat hold 0", 32'(cnt_sat), 0);
            checkOutput("sat hold0 carry", 32'(cy_sat), 1);
        end

        // Priority and clamp in 2..10
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
        checkOutput("pri load8", 32'(cnt_pri), 8);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        checkOutput("pri clear wins", 32'(cnt_pri), 5);
        applyStimulus(1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
        checkOutput("pri clamp hi", 32'(cnt_pri), 10);
        checkOutput("pri at_max", 32'(max_pri), 1);
        checkOutput("pri load carry", 32'(cy_pri), 0);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        checkOutput("pri clamp lo", 32'(cnt_pri), 2);
        checkOutput("pri at_min", 32'(min_pri), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
            checkOutput("pri hold", 32'(cnt_pri), 2);
            checkOutput("pri hold carry", 32'(cy_pri), 0);
        end

        // Async reset while count=7 and carry high
        applyStimulus(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        checkOutput("mid load12", 32'(cnt_mid), 12);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkOutput("mid wrap 7", 32'(cnt_mid), 7);
        checkOutput("mid carry", 32'(cy_mid), 1);
        en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async rst count", 32'(cnt_mid), 9);
        checkOutput("async rst carry", 32'(cy_mid), 0);
        checkOutput("async rst def", 32'(cnt_def), 0);
        #10;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkOutput("post rst hold", 32'(cnt_mid), 9);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
